// File: rtl/spi_resp.sv
// spi_resp: SPI mode-0 responder with a 16-byte register file.
//
// Every frame is 16 bits, MSB first: bit15 R/nW (1 = read), bits14:8 address,
// bits7:0 write data (ignored on reads). The SPI pins are oversampled on clk.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI    SPI slave inputs, asynchronous to clk
//   MISO                SPI data out, high-impedance while SS_n is high
//   ld, ld_addr, ld_data  local write into the register file
//   new_smpl            sets INT
//   INT                 data-ready flag; cleared by a completed read of INT_CLR_ADDR
//   wr_vld, wr_addr, wr_data  write-frame-done pulse plus held address and data
//   rd_vld              read-frame-done pulse
//   frm_err             pulse when a frame ends with a rise count other than 16
//
// States
//   state | meaning
//   IDLE  | no frame, waiting for an SS_n fall
//   CMD   | rises 0-7 seen, collecting R/nW and address
//   DATA  | rises 8-15 seen, read byte shifting out on MISO
//   WAIT  | exactly 16 rises seen, the frame is valid if SS_n rises now
//   OVR   | more than 16 rises seen, the frame will be flagged as an error
module spi_resp #(
  parameter logic [6:0] BASE         = 7'h20,
  parameter logic [7:0] ID           = 8'h6A,
  parameter logic [6:0] INT_CLR_ADDR = 7'h2D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       ld,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic       new_smpl,
  output logic       INT,
  output logic       wr_vld,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_vld,
  output logic       frm_err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT, OVR} state_t;

  state_t      state_q, state_d;
  // [0] first sync stage, [1] second sync stage, [2] edge-detect stage
  logic [2:0]  ss_q, ss_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [1:0]  mosi_q, mosi_d;
  // Marks when ss_q[1] holds a real pin sample rather than its reset value.
  logic [1:0]  vld_q, vld_d;
  logic        arm_q, arm_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        int_q, int_d;
  logic        wr_vld_q, wr_vld_d;
  logic        rd_vld_q, rd_vld_d;
  logic        frm_err_q, frm_err_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rf_q [16];
  logic [7:0]  rf_d [16];

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [7:0]  cmd_byte;
  logic [7:0]  rd_byte;
  logic        spi_wr;
  logic        miso_int;

  assign ss_fall   = arm_q & ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];

  // Command byte as it will stand once the current (8th) rise is shifted in.
  assign cmd_byte = {shift_q[6:0], mosi_q[1]};

  always_comb begin
    rd_byte = 8'h00;
    if (cmd_byte[6:0] == 7'h0F) begin
      rd_byte = ID;
    end else if (cmd_byte[6:4] == BASE[6:4]) begin
      rd_byte = rf_q[cmd_byte[3:0]];
    end
  end

  always_comb begin
    ss_d      = {ss_q[1:0], SS_n};
    sclk_d    = {sclk_q[1:0], SCLK};
    mosi_d    = {mosi_q[0], MOSI};
    vld_d     = {vld_q[0], 1'b1};
    arm_d     = arm_q | (vld_q[1] & ss_q[1]);
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    wr_vld_d  = 1'b0;
    rd_vld_d  = 1'b0;
    frm_err_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    spi_wr    = 1'b0;
    int_d     = int_q;
    rf_d      = rf_q;

    if (state_q != IDLE && sclk_rise) begin
      shift_d = {shift_q[14:0], mosi_q[1]};
      cnt_d   = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
          tx_d    = 8'h00;
        end
      end
      CMD: begin
        if (ss_rise) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (sclk_rise && cnt_q == 5'd7) begin
          tx_d    = cmd_byte[7] ? rd_byte : 8'h00;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ss_rise) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          if (sclk_rise && cnt_q == 5'd15) begin
            state_d = WAIT;
          end
          // The 8th fall arrives with cnt at 8 and must not shift: bit 7 is
          // still being presented.
          if (sclk_fall && cnt_q >= 5'd9) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      WAIT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (shift_q[15]) begin
            rd_vld_d = 1'b1;
            if (shift_q[14:8] == INT_CLR_ADDR) begin
              int_d = 1'b0;
            end
          end else begin
            wr_vld_d  = 1'b1;
            wr_addr_d = shift_q[14:8];
            wr_data_d = shift_q[7:0];
            spi_wr    = (shift_q[14:12] == BASE[6:4]) && (shift_q[14:8] != 7'h0F);
          end
        end else if (sclk_rise) begin
          state_d = OVR;
        end
      end
      OVR: begin
        if (ss_rise) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // SPI write is applied after ld so it wins on an index collision.
    if (ld) begin
      rf_d[ld_addr] = ld_data;
    end
    if (spi_wr) begin
      rf_d[shift_q[11:8]] = shift_q[7:0];
    end

    if (new_smpl) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ss_q      <= 3'b111;
      sclk_q    <= 3'b000;
      mosi_q    <= 2'b00;
      vld_q     <= 2'b00;
      arm_q     <= 1'b0;
      cnt_q     <= 5'd0;
      shift_q   <= 16'h0000;
      tx_q      <= 8'h00;
      int_q     <= 1'b0;
      wr_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      frm_err_q <= 1'b0;
      wr_addr_q <= 7'h00;
      wr_data_q <= 8'h00;
      rf_q      <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      vld_q     <= vld_d;
      arm_q     <= arm_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      int_q     <= int_d;
      wr_vld_q  <= wr_vld_d;
      rd_vld_q  <= rd_vld_d;
      frm_err_q <= frm_err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rf_q      <= rf_d;
    end
  end

  assign miso_int = (state_q == DATA || state_q == WAIT || state_q == OVR) ? tx_q[7] : 1'b0;
  assign MISO     = SS_n ? 1'bz : miso_int;

  assign INT     = int_q;
  assign wr_vld  = wr_vld_q;
  assign rd_vld  = rd_vld_q;
  assign frm_err = frm_err_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_spi_resp.sv
// Testbench for spi_resp: drives SPI frames from a task, keeps a model of the
// register file and INT, and scores completion pulses against a queue.
module tb_spi_resp;

  localparam logic [6:0] BASE         = 7'h20;
  localparam logic [7:0] ID           = 8'h6A;
  localparam logic [6:0] INT_CLR_ADDR = 7'h2D;
  localparam int         HALF         = 10;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       SCLK;
  logic       MOSI;
  wire        miso;
  logic       ld;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       new_smpl;
  logic       INT;
  logic       wr_vld;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_vld;
  logic       frm_err;

  spi_resp #(.BASE(BASE), .ID(ID), .INT_CLR_ADDR(INT_CLR_ADDR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (miso),
    .ld       (ld),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .new_smpl (new_smpl),
    .INT      (INT),
    .wr_vld   (wr_vld),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_vld   (rd_vld),
    .frm_err  (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;   // {frm_err, rd_vld, wr_vld}
    logic [6:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mdl_rf [16];
  logic       mdl_int;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl_read(input logic [6:0] a);
    if (a == 7'h0F) return ID;
    if (a[6:4] == BASE[6:4]) return mdl_rf[a[3:0]];
    return 8'h00;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl_rf[i] = 8'h00;
    mdl_int = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (wr_vld || rd_vld || frm_err)) begin
      if (sb.size() == 0) begin
        chk("sb_extra", {29'd0, frm_err, rd_vld, wr_vld}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_kind", {29'd0, frm_err, rd_vld, wr_vld}, {29'd0, mon_e.kind});
        chk("ev_latency", cyc, mon_e.cyc);
        if (mon_e.kind == 3'b001) begin
          chk("wr_addr", {25'd0, wr_addr}, {25'd0, mon_e.addr});
          chk("wr_data", {24'd0, wr_data}, {24'd0, mon_e.data});
        end
      end
    end
  end

  task automatic ld_pulse(input logic [3:0] idx, input logic [7:0] dat);
    @(negedge clk);
    ld = 1'b1; ld_addr = idx; ld_data = dat;
    @(negedge clk);
    ld = 1'b0;
    mdl_rf[idx] = dat;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mdl_clear();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic spi_frame(input int n_rises, input logic [15:0] word, input int rst_at,
                           input bit mid_ld, input logic [3:0] mid_idx, input logic [7:0] mid_dat,
                           input bit end_ld, input logic [3:0] end_idx, input logic [7:0] end_dat,
                           input bit end_smpl);
    logic [15:0] sh;
    logic [7:0]  rx, cmd_rx, exp_rx;
    logic [6:0]  a;
    bit          rd, done;
    ev_t         e;
    a      = word[14:8];
    rd     = word[15];
    exp_rx = rd ? mdl_read(a) : 8'h00;
    done   = (n_rises == 16) && (rst_at == 0);
    sh     = word;
    rx     = 8'h00;
    cmd_rx = 8'h00;
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < n_rises; i++) begin
      MOSI = sh[15];
      sh   = sh << 1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      if (i < 8) cmd_rx = {cmd_rx[6:0], miso};
      else if (i < 16) rx = {rx[6:0], miso};
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      if (mid_ld && i == 9) ld_pulse(mid_idx, mid_dat);
      if (rst_at == i + 1) do_reset();
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    if (rst_at == 0) begin
      e.addr = a;
      e.data = word[7:0];
      e.cyc  = cyc + 3;
      e.kind = (n_rises != 16) ? 3'b100 : (rd ? 3'b010 : 3'b001);
      sb.push_back(e);
    end
    if (end_ld || end_smpl) begin
      repeat (2) @(negedge clk);
      ld = end_ld; ld_addr = end_idx; ld_data = end_dat;
      new_smpl = end_smpl;
      @(negedge clk);
      ld = 1'b0; new_smpl = 1'b0;
      if (end_ld) mdl_rf[end_idx] = end_dat;
    end
    if (done) begin
      if (!rd && a[6:4] == BASE[6:4] && a != 7'h0F) mdl_rf[a[3:0]] = word[7:0];
      if (rd && a == INT_CLR_ADDR) mdl_int = 1'b0;
    end
    if (end_smpl) mdl_int = 1'b1;
    repeat (8) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    chk("int", {31'd0, INT}, {31'd0, mdl_int});
    if (done) begin
      chk("cmd_miso", {24'd0, cmd_rx}, 32'd0);
      chk(rd ? "rd_data" : "wr_miso", {24'd0, rx}, {24'd0, exp_rx});
    end
  endtask

  task automatic frame(input int n_rises, input logic [15:0] word);
    spi_frame(n_rises, word, 0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_int"},     {31'd0, INT}, 32'd0);
    chk({tag, "_wr_vld"},  {31'd0, wr_vld}, 32'd0);
    chk({tag, "_rd_vld"},  {31'd0, rd_vld}, 32'd0);
    chk({tag, "_frm_err"}, {31'd0, frm_err}, 32'd0);
    chk({tag, "_wr_addr"}, {25'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    ld = 1'b0; ld_addr = 4'h0; ld_data = 8'h00; new_smpl = 1'b0;
    mdl_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset");
    repeat (5) @(negedge clk);

    // Local load then SPI read back; INT must not move.
    ld_pulse(4'h4, 8'hA5);
    frame(16, 16'hA400);

    // SPI write then read back.
    frame(16, 16'h2B3C);
    frame(16, 16'hAB00);

    // ID and out-of-range reads; write to ID address leaves it alone.
    frame(16, 16'h8F00);
    frame(16, 16'hD000);
    frame(16, 16'h0F55);
    frame(16, 16'h8F00);
    frame(16, 16'h5077);

    // INT set, cleared by read of the clear address, set wins on collision.
    @(negedge clk); new_smpl = 1'b1;
    @(negedge clk); new_smpl = 1'b0;
    mdl_int = 1'b1;
    repeat (4) @(negedge clk);
    chk("int_set", {31'd0, INT}, 32'd1);
    frame(16, 16'hAD00);
    spi_frame(16, 16'hAD00, 0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1);
    frame(16, 16'hAB00);

    // Short and long frames are errors and change nothing.
    frame(12, 16'h2455);
    frame(17, 16'h2477);
    frame(16, 16'hA400);

    // ld during the data phase does not disturb the byte already captured.
    spi_frame(16, 16'hA400, 0, 1'b1, 4'h4, 8'h5A, 1'b0, 4'h0, 8'h00, 1'b0);
    frame(16, 16'hA400);

    // SPI write and ld in the same cycle: same index SPI wins, other index both land.
    spi_frame(16, 16'h2F11, 0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'hEE, 1'b0);
    frame(16, 16'hAF00);
    spi_frame(16, 16'h2E22, 0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'h33, 1'b0);
    frame(16, 16'hAE00);
    frame(16, 16'hA300);

    // Reset in the middle of a write frame.
    spi_frame(16, 16'h2155, 10, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);
    chk_idle_outputs("midrst");
    frame(16, 16'hA100);
    frame(16, 16'hA400);
    frame(16, 16'h2199);
    frame(16, 16'hA100);

    repeat (10) @(negedge clk);
    chk("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
